// File: rtl/key_event_pkg.sv
// Shared types and default timing constants for the key event decoder.
// The clock constant is the same one the debouncer is built against.
package key_event_pkg;

    localparam int CLK_HZ = 50_000_000;

    // Default event timing at CLK_HZ: 1 s long press, 300 ms click gap, 200 ms repeat.
    localparam int LONG_CNT_DEF   = CLK_HZ;
    localparam int DCLICK_CNT_DEF = (CLK_HZ / 10) * 3;
    localparam int REPEAT_CNT_DEF = CLK_HZ / 5;
    localparam int CNT_W_DEF      = 26;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG
    } state_t;

endpackage

// File: rtl/key_event.sv
// Decodes the debounced active-low key level into short/double/long/repeat pulses.
// The repeat pulse is named repeat_pulse because "repeat" is a reserved word.
module key_event
    import key_event_pkg::*;
#(
    parameter int LONG_CNT   = LONG_CNT_DEF,
    parameter int DCLICK_CNT = DCLICK_CNT_DEF,
    parameter int REPEAT_CNT = REPEAT_CNT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_db,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic key_held
);

    localparam logic [CNT_W-1:0] LONG_END   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DCLICK_END = CNT_W'(DCLICK_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_END = CNT_W'(REPEAT_CNT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer;
    logic             key_d;
    logic             fall, rise;
    logic             tmr_clr;
    logic             short_nxt, dbl_nxt, long_nxt, rpt_nxt;

    // key_d resets high so a key held through reset shows up as a fresh fall.
    assign fall = key_d & ~key_db;
    assign rise = ~key_d & key_db;

    always_comb begin
        state_nxt = state;
        short_nxt = 1'b0;
        dbl_nxt   = 1'b0;
        long_nxt  = 1'b0;
        rpt_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (rise) begin
                    state_nxt = WAIT2;
                end else if (timer == LONG_END) begin
                    state_nxt = LONG;
                    long_nxt  = 1'b1;
                end
            end
            WAIT2: begin
                if (fall) begin
                    state_nxt = PRESS2;
                end else if (timer == DCLICK_END) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                end
            end
            PRESS2: begin
                // No long detection here: a held second press still ends as a double click.
                if (rise) begin
                    state_nxt = IDLE;
                    dbl_nxt   = 1'b1;
                end
            end
            LONG: begin
                if (rise) begin
                    state_nxt = IDLE;
                end else if (timer == REPEAT_END) begin
                    rpt_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        tmr_clr = (state_nxt != state) || rpt_nxt || (state == IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            timer        <= '0;
            key_d        <= 1'b1;
            short_press  <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            key_held     <= 1'b0;
        end else begin
            state        <= state_nxt;
            key_d        <= key_db;
            timer        <= tmr_clr ? '0 : timer + CNT_W'(1);
            short_press  <= short_nxt;
            double_click <= dbl_nxt;
            long_press   <= long_nxt;
            repeat_pulse <= rpt_nxt;
            key_held     <= (state_nxt == LONG);
        end
    end

endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Consumer end of the debounced key line: takes the clean, active-low key level produced by the debouncer and decodes it into one-cycle event pulses.
- Events: short press, double click, long press, auto-repeat while held.
- Sits between the debouncer and the LED/mode control logic in the key-controlled-LED design.
- All outputs are registered; the block is a single FSM plus one shared timer.

Parameters:
- LONG_CNT, 50_000_000, cycles a press must last to become a long press (1 s at 50 MHz).
- DCLICK_CNT, 15_000_000, maximum release gap between two presses for a double click (300 ms).
- REPEAT_CNT, 10_000_000, period of repeat pulses while long-held (200 ms).
- CNT_W, 26, timer width; must satisfy 2^CNT_W > max(LONG_CNT, DCLICK_CNT, REPEAT_CNT).

Ports:
- clk  input  1  system clock, 50 MHz
- rstn  input  1  asynchronous active-low reset
- key_db  input  1  debounced key level; 1 = released (idle), 0 = pressed
- short_press  output  1  one-cycle pulse: single short press confirmed
- double_click  output  1  one-cycle pulse: second press released within the gap window
- long_press  output  1  one-cycle pulse: press reached LONG_CNT
- repeat  output  1  one-cycle pulse every REPEAT_CNT cycles while in long hold
- key_held  output  1  level, high while in long hold

Behaviour:
- Reset: rstn=0 forces state IDLE, timer 0, key_d=1, and all outputs 0, asynchronously, at any point mid-operation. A key still low after reset release is detected as a new fall and treated as a fresh press.
- Edge detect:
  - key_d registers key_db each cycle.
  - fall = key_d & ~key_db; rise = ~key_d & key_db.
  - key_db is already synchronous; no extra synchronizer.
- Timer: one CNT_W counter, cleared on every state change and incremented otherwise. In IDLE it holds 0.
- States: IDLE, PRESS1, WAIT2, PRESS2, LONG.
- IDLE:
  - fall -> PRESS1.
- PRESS1:
  - rise -> WAIT2.
  - else, timer==LONG_CNT-1 -> LONG and long_press=1.
  - If rise and timeout fall on the same edge, rise wins: short path, no long_press.
- WAIT2:
  - fall -> PRESS2.
  - else, timer==DCLICK_CNT-1 -> IDLE and short_press=1.
  - If fall and timeout fall on the same edge, fall wins: double path.
- PRESS2:
  - rise -> IDLE and double_click=1.
  - No long detection in the second press; a held second press still gives double_click on release.
- LONG:
  - key_held=1.
  - rise -> IDLE, key_held=0, no short_press.
  - else, timer==REPEAT_CNT-1 -> repeat=1 and timer cleared.
  - If rise and repeat timeout fall on the same edge, rise wins: no repeat.
- Timing and output rules:
  - All pulses and key_held changes appear in the cycle immediately after the edge where the transition is taken. Latency is 1 cycle from the decision edge.
  - At most one event pulse is high in any cycle.
  - Events are mutually exclusive per press sequence: a sequence yields exactly one of short_press, double_click, or long_press (long_press may be followed by repeats).
- Timing reference:
  - E0 is the edge at which the fall is detected; the timer equals k at E0+k.
  - long_press is high in the cycle after E0+LONG_CNT.

Decomposition:
- Package key_event_pkg holds:
  - the state enum (IDLE, PRESS1, WAIT2, PRESS2, LONG);
  - default constants for LONG_CNT, DCLICK_CNT and REPEAT_CNT at 50 MHz;
  - the clock-frequency constant shared with the debouncer.
- No sub-module is required; the edge detect and timer stay inline. The debouncer instance feeding key_db lives in the parent, not here.

Test Plan (sim parameters LONG_CNT=20, DCLICK_CNT=10, REPEAT_CNT=5):
- Short press: press 5 cycles, release, idle 20 -> exactly one short_press, 10 cycles after release detection; no other pulses.
- Double click: press 5, release 4, press 5, release -> double_click 1 cycle after second release detection; no short_press.
- Long hold: hold 40 cycles from E0 -> long_press after E0+20, key_held high from then, repeat after E0+25, E0+30, E0+35 (rise at E0+40 beats the fourth); on release key_held=0 and no short_press.
- Long/release boundary: release detected exactly at E0+20 -> WAIT2 path, no long_press; short_press 10 cycles later.
- Double-click boundary: second fall detected exactly on the WAIT2 timeout edge -> no short_press; double_click on that press's release.
- Reset in LONG: drop rstn mid-hold -> key_held and all pulses 0 immediately. Release rstn with key still low -> treated as a new press; long_press 20 cycles after detection.
